// File: rtl/select_action_sched_pkg.sv
// Shared types for the select_action scheduler: operand/mode types, FSM states
// and sizing constants used by the scheduler and its arbiter.
package select_action_sched_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } opr_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    RESPOND = 2'd2
  } sched_state_t;

  localparam int MAX_REQ    = 8;
  localparam int SETTLE_W   = 4;
  localparam int MAX_SETTLE = (1 << SETTLE_W) - 1;

endpackage

// File: rtl/select_action_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching
// upward from the slot after the last grant, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_grant
);

  int unsigned k;

  always_comb begin
    gnt       = '0;
    idx       = '0;
    any_grant = 1'b0;
    k         = 0;
    // Offsets 1..N visit ptr+1 first and the last winner last.
    for (int unsigned i = 1; i <= N; i++) begin
      k = (i + 32'(ptr)) % N;
      if (!any_grant && req[k]) begin
        any_grant = 1'b1;
        gnt[k]    = 1'b1;
        idx       = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/select_action_sched.sv
// Round-robin scheduler sharing one combinational select_action datapath
// between NUM_REQ requesters over valid/ready request and response channels.
module select_action_sched
  import select_action_sched_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic      [NUM_REQ-1:0]   REQ_VALID,
  output logic      [NUM_REQ-1:0]   REQ_READY,
  input  opr_mode_t [NUM_REQ-1:0]   REQ_MODE,
  input  word_t     [NUM_REQ-1:0]   REQ_SW,
  output logic      [NUM_REQ-1:0]   RSP_VALID,
  input  logic      [NUM_REQ-1:0]   RSP_READY,
  output word_t                     RSP_DATA,
  output opr_mode_t                 SELECTOR,
  output word_t                     SW,
  input  word_t                     LED,
  output logic                      BUSY
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("select_action_sched: NUM_REQ must be in 2..%0d", MAX_REQ);
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_settle
    $error("select_action_sched: SETTLE_CYCLES must be in 1..%0d", MAX_SETTLE);
  end

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t          state_q, state_d;
  logic [IW-1:0]         ptr_q;
  logic [SETTLE_W-1:0]   cnt_q;
  opr_mode_t             sel_q;
  word_t                 sw_q;
  word_t                 data_q;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req       (REQ_VALID),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .idx       (arb_idx),
    .any_grant (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    REQ_READY = '0;
    RSP_VALID = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          REQ_READY = arb_gnt;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_W'(1)) state_d = RESPOND;
      end
      RESPOND: begin
        // ptr_q holds the index of the transaction in flight until IDLE.
        RSP_VALID[ptr_q] = 1'b1;
        if (RSP_READY[ptr_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      sel_q   <= ADD;
      sw_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            sel_q <= REQ_MODE[arb_idx];
            sw_q  <= REQ_SW[arb_idx];
            ptr_q <= arb_idx;
            cnt_q <= SETTLE_W'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - SETTLE_W'(1);
          if (cnt_q == SETTLE_W'(1)) data_q <= LED;
        end
        default: ;
      endcase
    end
  end

  assign SELECTOR = sel_q;
  assign SW       = sw_q;
  assign RSP_DATA = data_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_select_action_sched.sv
// Directed bench for select_action_sched with an LED = SW + 1 datapath stub;
// a second instance covers SETTLE_CYCLES = 4.
module tb_select_action_sched;
  import select_action_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // SETTLE_CYCLES = 1 instance
  logic            [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  opr_mode_t       [1:0] req_mode;
  word_t           [1:0] req_sw;
  word_t                 rsp_data, sw, led;
  opr_mode_t             selector;
  logic                  busy;

  // SETTLE_CYCLES = 4 instance
  logic            [1:0] req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  opr_mode_t       [1:0] req_mode4;
  word_t           [1:0] req_sw4;
  word_t                 rsp_data4, sw4, led4;
  opr_mode_t             selector4;
  logic                  busy4;

  int checks = 0;
  int errors = 0;

  assign led  = sw + 16'h0001;
  assign led4 = sw4 + 16'h0001;

  select_action_sched #(.NUM_REQ(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_MODE(req_mode), .REQ_SW(req_sw),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .SELECTOR(selector), .SW(sw), .LED(led), .BUSY(busy)
  );

  select_action_sched #(.NUM_REQ(2), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .REQ_VALID(req_valid4), .REQ_READY(req_ready4), .REQ_MODE(req_mode4), .REQ_SW(req_sw4),
    .RSP_VALID(rsp_valid4), .RSP_READY(rsp_ready4), .RSP_DATA(rsp_data4),
    .SELECTOR(selector4), .SW(sw4), .LED(led4), .BUSY(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (selector !== ADD) begin errors++; $display("FAIL reset_selector got %0d exp %0d", selector, ADD); end
    checks++; if (sw !== 16'h0000) begin errors++; $display("FAIL reset_sw got %h exp 0000", sw); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_mode[0] = ADD; req_sw[0] = 16'h0004;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00; req_sw[0] = 16'hDEAD;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t1 got %b exp 1", busy); end
    checks++; if (sw !== 16'h0004) begin errors++; $display("FAIL single_sw got %h exp 0004", sw); end
    checks++; if (selector !== ADD) begin errors++; $display("FAIL single_selector got %0d exp %0d", selector, ADD); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_early got %b exp 00", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_data !== 16'h0005) begin errors++; $display("FAIL single_rsp_data got %h exp 0005", rsp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t2 got %b exp 1", busy); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_drop got %b exp 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    word_t      exp_d;
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_mode[0] = ADD; req_sw[0] = 16'h0010;
    req_mode[1] = OR;  req_sw[1] = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 16'h0011 : 16'h0021;
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", i, req_ready, exp_g); end
      tick();
      checks++; if (selector !== ((i % 2 == 0) ? ADD : OR)) begin errors++; $display("FAIL cont_selector%0d got %0d", i, selector); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cont_ready_settle%0d got %b exp 00", i, req_ready); end
      tick();
      checks++; if (rsp_valid !== exp_g) begin errors++; $display("FAIL cont_rsp_valid%0d got %b exp %b", i, rsp_valid, exp_g); end
      checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL cont_rsp_data%0d got %h exp %h", i, rsp_data, exp_d); end
      if (i == 3) req_valid = 2'b00;
      tick();
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    // Last grant was requester 1, so requester 0 wins next.
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0 got %b exp 01", req_ready); end
    tick();
    tick();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_hold_valid%0d got %b exp 01", i, rsp_valid); end
      checks++; if (rsp_data !== 16'h0011) begin errors++; $display("FAIL bp_hold_data%0d got %h exp 0011", i, rsp_data); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready1_%0d got %b exp 00", i, req_ready); end
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_still_valid got %b exp 01", rsp_valid); end
    tick();
    rsp_ready = 2'b00;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant1 got %b exp 10", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_bubble_busy got %b exp 0", busy); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_data !== 16'h0021) begin errors++; $display("FAIL bp_rsp1_data got %h exp 0021", rsp_data); end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_rsp1_valid got %b exp 10", rsp_valid); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; req_sw[1] = 16'h0100;
    tick();
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_settle_busy got %b exp 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (sw !== 16'h0000) begin errors++; $display("FAIL rmid_sw got %h exp 0000", sw); end
    checks++; if (selector !== ADD) begin errors++; $display("FAIL rmid_selector got %0d exp %0d", selector, ADD); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL rmid_rsp_data got %h exp 0000", rsp_data); end
    tick();
    reset = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmid_no_rsp%0d got %b exp 00", i, rsp_valid); end
    end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_first_grant got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_settle4();
    req_valid4 = 2'b01; req_mode4[0] = SUB; req_sw4[0] = 16'hFFFF;
    #1;
    checks++; if (req_ready4 !== 2'b01) begin errors++; $display("FAIL s4_req_ready got %b exp 01", req_ready4); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      req_valid4 = 2'b00; req_sw4[0] = 16'h1234; req_mode4[0] = XOR;
      checks++; if (sw4 !== 16'hFFFF || selector4 !== SUB) begin errors++; $display("FAIL s4_hold_t%0d got sw %h sel %0d exp FFFF %0d", k, sw4, selector4, SUB); end
      checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL s4_busy_t%0d got %b exp 1", k, busy4); end
      if (k < 5) begin
        checks++; if (rsp_valid4 !== 2'b00) begin errors++; $display("FAIL s4_early_t%0d got %b exp 00", k, rsp_valid4); end
      end else begin
        checks++; if (rsp_valid4 !== 2'b01) begin errors++; $display("FAIL s4_rsp_valid got %b exp 01", rsp_valid4); end
        checks++; if (rsp_data4 !== 16'h0000) begin errors++; $display("FAIL s4_rsp_data got %h exp 0000", rsp_data4); end
      end
    end
    rsp_ready4 = 2'b01;
    tick();
    rsp_ready4 = 2'b00;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL s4_idle got %b exp 0", busy4); end
  endtask

  initial begin
    req_valid = '0; rsp_ready = '0; req_mode = {ADD, ADD}; req_sw = '0;
    req_valid4 = '0; rsp_ready4 = '0; req_mode4 = {ADD, ADD}; req_sw4 = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_settle4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_action_sched.md
Name: select_action_sched

Overview:
- Round-robin scheduler that shares one combinational select_action datapath between NUM_REQ requesters.
- Each requester presents a mode (opr_mode_t) and a 16-bit operand (word_t) over a valid/ready handshake.
- The block drives SELECTOR/SW to the shared datapath, waits SETTLE_CYCLES, captures LED, and returns the result over a per-requester valid/ready response.
- It sits between the switch/command front-ends and the single select_action instance.

Parameters:
- NUM_REQ, 2: number of requesters. Legal range 2..8; any other value is an elaboration error.
- SETTLE_CYCLES, 1: clock cycles SELECTOR/SW are held before LED is captured. Legal range 1..15; any other value is an elaboration error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  one-hot accept pulse.
- REQ_MODE  in  NUM_REQ x opr_mode_t  requested operation.
- REQ_SW  in  NUM_REQ x word_t  requested operand.
- RSP_VALID  out  NUM_REQ  one-hot result valid.
- RSP_READY  in  NUM_REQ  per-requester result accept.
- RSP_DATA  out  word_t  result; shared bus, meaningful only where RSP_VALID is set.
- SELECTOR  out  opr_mode_t  to select_action.SELECTOR.
- SW  out  word_t  to select_action.SW.
- LED  in  word_t  from select_action.LED.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE; grant pointer = NUM_REQ-1, so requester 0 wins first.
  - SELECTOR = ADD; SW = '0; RSP_DATA = '0.
  - REQ_READY = '0; RSP_VALID = '0; BUSY = 0.
  - Reset mid-operation abandons the transaction. No response is issued.
- FSM states: IDLE, SETTLE, RESPOND.
- IDLE:
  - If any REQ_VALID is set, grant the first set bit searching upward from (ptr+1) mod NUM_REQ, wrapping.
  - In the same cycle, assert REQ_READY[g] combinationally. The accept cycle is T.
  - At the edge ending T: register SELECTOR <= REQ_MODE[g], SW <= REQ_SW[g], ptr <= g, load settle counter = SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - SELECTOR/SW are held stable. The counter decrements each cycle.
  - On the cycle the counter reads 1: capture RSP_DATA <= LED at the edge and go to RESPOND.
- RESPOND:
  - RSP_VALID[g] = 1, RSP_DATA is stable, SELECTOR/SW are held.
  - When RSP_READY[g] = 1, go to IDLE at that edge.
  - RSP_VALID stays high indefinitely until accepted (backpressure).
- Latency: accept at cycle T gives RSP_VALID high from cycle T+1+SETTLE_CYCLES.
- Minimum issue interval: SETTLE_CYCLES+2 cycles. There is one IDLE cycle between transactions, so RSP_READY and a new REQ_VALID in the same cycle still produce a one-cycle bubble.
- Requester protocol:
  - REQ_VALID must be held with stable REQ_MODE/REQ_SW until REQ_READY.
  - Inputs are sampled only in the accept cycle. Changes afterwards have no effect.
- Non-granted requesters see REQ_READY = 0 and wait. Only the granted index may ever see REQ_READY or RSP_VALID.
- RSP_READY on a non-granted index is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Width rules:
  - RSP_DATA is exactly word_t. No extension or truncation; overflow behaviour belongs to select_action.
  - Index g is $clog2(NUM_REQ) bits.

Decomposition:
- Add to types_pkg:
  - sched_state_t enum {IDLE, SETTLE, RESPOND}.
  - MAX_REQ = 8 constant.
  - SETTLE_W = 4 counter width.
- Sub-module rr_arbiter (parameter N): purely combinational.
  - Inputs: request vector, last-grant pointer.
  - Outputs: one-hot grant, grant index, any_grant.
- select_action is instantiated by the parent, not inside this block.

Test Plan:
- In the unit bench, a stub drives LED = SW + 16'h0001 combinationally. The integration bench uses the real select_action.
- Single request: REQ_VALID[0]=1, MODE=ADD, SW=16'h0004 at T -> REQ_READY[0] at T, SELECTOR=ADD/SW=16'h0004 from T+1, RSP_VALID[0] at T+2 with RSP_DATA=16'h0005, BUSY=1 T+1..T+2 (SETTLE_CYCLES=1).
- Contention: both valid continuously, SW0=16'h0010, SW1=16'h0020, RSP_READY tied high -> grants 0,1,0,1, one every 3 cycles; RSP_DATA alternates 16'h0011/16'h0021.
- Backpressure: RSP_READY[0]=0 for 5 cycles -> RSP_VALID[0] and RSP_DATA held; REQ_READY[1]=0 throughout despite REQ_VALID[1]=1; grant to 1 in the IDLE cycle after accept.
- Reset mid-SETTLE: assert reset asynchronously -> all outputs return to reset values immediately; no RSP_VALID after release; first post-reset grant goes to requester 0.
- SETTLE_CYCLES=4, SW=16'hFFFF -> RSP_VALID at T+5, RSP_DATA=16'h0000 (stub wrap); SELECTOR/SW stable T+1..T+5.
